axis_ddr3_burst_writer: RTL and testbench

- Upstream feeder for the DDR3 core's AXI4 write port.
- Accepts an AXI-Stream of WIDTH-bit words and packs them into fixed-length INCR write bursts (BURST_LEN beats) at consecutive addresses from a programmed base.
- Tracks outstanding write responses and reports completion and errors.
- Used by capture/DMA paths that stream data into SDRAM.

---
 rtl/ddr3_axi_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 86 ++++++++
 rtl/axis_ddr3_burst_writer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axis_ddr3_burst_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_axi_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_axi_pkg
// Shared definitions for the blocks that feed the DDR3 core's AXI4 ports:
//   - AXI burst type and response encodings
//   - state encoding of the AXI-Stream burst writer FSM
//   - clog2 helper used to size FIFO pointers and counters
// ---------------------------------------------------------------------------
package ddr3_axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BW_IDLE  = 2'd0,
        BW_FILL  = 2'd1,
        BW_BURST = 2'd2,
        BW_FLUSH = 2'd3
    } bw_state_e;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int pow;
        result = 0;
        pow    = 1;
        for (int i = 0; i < 31; i++) begin
            if (pow < value) begin
                pow    = pow * 2;
                result = result + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with an occupancy count.
//   clock, reset      : clock and synchronous active-high reset (empties FIFO)
//   push_i, data_i    : write strobe and data (ignored while full)
//   pop_i             : read strobe (ignored while empty)
//   data_o            : current head word, valid whenever empty_o is low
//   full_o, empty_o   : status flags
//   count_o           : number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo
    import ddr3_axi_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; pointers wrap at DEPTH-1 so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axis_ddr3_burst_writer.sv
// ---------------------------------------------------------------------------
// axis_ddr3_burst_writer
// Packs an AXI-Stream of WIDTH-bit words into fixed-length INCR bursts on the
// DDR3 core's AXI4 write port, at consecutive addresses from base_i.
//   clock, reset                 : clock, synchronous active-high reset
//   start_i, base_i              : start a transfer at a burst-aligned address
//   busy_o, done_o, err_o        : in progress / completion pulse / sticky BRESP error
//   s_t*                         : AXI-Stream input (tlast marks the final word)
//   axi_aw*, axi_w*, axi_b*      : AXI4 write address, data and response channels
// A short final burst is padded with zero-strobe beats so every burst is
// BURST_LEN beats long. At most MAX_OUTST bursts wait for a B response.
// ---------------------------------------------------------------------------
module axis_ddr3_burst_writer
    import ddr3_axi_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDRS     = 27,
    parameter int REQID     = 4,
    parameter int BURST_LEN = 4,
    parameter int MAX_OUTST = 2,
    parameter int AXI_ID    = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [ADDRS-1:0]     base_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic                 s_tvalid_i,
    output logic                 s_tready_o,
    input  logic                 s_tlast_i,
    input  logic [WIDTH-1:0]     s_tdata_i,
    output logic                 axi_awvalid_o,
    input  logic                 axi_awready_i,
    output logic [ADDRS-1:0]     axi_awaddr_o,
    output logic [REQID-1:0]     axi_awid_o,
    output logic [7:0]           axi_awlen_o,
    output logic [1:0]           axi_awburst_o,
    output logic                 axi_wvalid_o,
    input  logic                 axi_wready_i,
    output logic                 axi_wlast_o,
    output logic [WIDTH/8-1:0]   axi_wstrb_o,
    output logic [WIDTH-1:0]     axi_wdata_o,
    input  logic                 axi_bvalid_i,
    output logic                 axi_bready_o,
    input  logic [1:0]           axi_bresp_i,
    input  logic [REQID-1:0]     axi_bid_i
);

    localparam int DEPTH     = 2 * BURST_LEN;
    localparam int CNT_W     = clog2(DEPTH + 1);
    localparam int BEAT_W    = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);
    localparam int OUT_W     = (clog2(MAX_OUTST + 1) < 1) ? 1 : clog2(MAX_OUTST + 1);
    localparam int STRB_W    = WIDTH / 8;
    localparam int ADDR_STEP = BURST_LEN * WIDTH / 8;

    bw_state_e          state_q, state_d;
    logic [ADDRS-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               last_seen_q, last_seen_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   outst_q, outst_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [WIDTH-1:0]   fifo_head;

    logic               aw_hs;
    logic               w_hs;
    logic               last_beat;
    logic               burst_end;
    logic               start_ok;
    logic               outst_inc;
    logic               outst_dec;
    logic               room;
    logic               eff_last;
    logic [CNT_W-1:0]   eff_count;
    logic [CNT_W-1:0]   count_after;
    logic               bid_unused;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (s_tdata_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bid_unused  = ^axi_bid_i;
    assign fifo_push   = s_tvalid_i & s_tready_o;
    assign aw_hs       = axi_awvalid_o & axi_awready_i;
    assign w_hs        = axi_wvalid_o & axi_wready_i;
    assign last_beat   = (beat_q == BEAT_W'(BURST_LEN - 1));
    // A burst retires only when both its address and its final data beat are accepted.
    assign burst_end   = (state_q == BW_BURST) & (aw_done_q | aw_hs) & (w_done_q | (w_hs & last_beat));
    assign fifo_pop    = w_hs & ~fifo_empty;
    assign start_ok    = (state_q == BW_IDLE) & start_i;
    // Fill level and tlast as they will be after this cycle's push; this lets
    // AWVALID rise the cycle right after the BURST_LEN-th word is accepted.
    assign eff_count   = fifo_count + CNT_W'(fifo_push);
    assign eff_last    = last_seen_q | (fifo_push & s_tlast_i);
    assign count_after = eff_count - CNT_W'(fifo_pop);
    assign room        = (outst_q < OUT_W'(MAX_OUTST));
    assign outst_inc   = burst_end;
    // A B with nothing outstanding belongs to a burst forgotten by reset.
    assign outst_dec   = axi_bvalid_i & axi_bready_o & (outst_q != {OUT_W{1'b0}});

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BW_IDLE: begin
                if (start_i) begin
                    state_d = BW_FILL;
                end else begin
                    state_d = BW_IDLE;
                end
            end
            BW_FILL: begin
                if (room && ((eff_count >= CNT_W'(BURST_LEN)) ||
                             (eff_last && (eff_count != {CNT_W{1'b0}})))) begin
                    state_d = BW_BURST;
                end else begin
                    state_d = BW_FILL;
                end
            end
            BW_BURST: begin
                if (burst_end) begin
                    if (last_seen_q && (count_after == {CNT_W{1'b0}})) begin
                        state_d = BW_FLUSH;
                    end else begin
                        state_d = BW_FILL;
                    end
                end else begin
                    state_d = BW_BURST;
                end
            end
            BW_FLUSH: begin
                if (outst_d == {OUT_W{1'b0}}) begin
                    state_d = BW_IDLE;
                end else begin
                    state_d = BW_FLUSH;
                end
            end
            default: state_d = BW_IDLE;
        endcase
    end

    // FSM outputs: channel valids, beat payload and stream ready.
    always_comb begin
        busy_o        = (state_q != BW_IDLE);
        axi_awvalid_o = (state_q == BW_BURST) & ~aw_done_q;
        axi_wvalid_o  = (state_q == BW_BURST) & ~w_done_q;
        axi_wlast_o   = axi_wvalid_o & last_beat;
        s_tready_o    = busy_o & ~fifo_full & ~last_seen_q;
        // Once the FIFO runs dry inside a burst, the remaining beats are padding.
        if (axi_wvalid_o && !fifo_empty) begin
            axi_wstrb_o = {STRB_W{1'b1}};
            axi_wdata_o = fifo_head;
        end else begin
            axi_wstrb_o = {STRB_W{1'b0}};
            axi_wdata_o = {WIDTH{1'b0}};
        end
    end

    // Next-state for address, beat, handshake flags, outstanding count and status.
    always_comb begin
        addr_d      = addr_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        last_seen_d = last_seen_q;
        err_d       = err_q;
        outst_d     = outst_q;
        done_d      = 1'b0;

        if (start_ok) begin
            addr_d      = base_i;
            last_seen_d = 1'b0;
        end else if (burst_end) begin
            addr_d      = addr_q + ADDRS'(ADDR_STEP);
            last_seen_d = last_seen_q | (fifo_push & s_tlast_i);
        end else begin
            addr_d      = addr_q;
            last_seen_d = last_seen_q | (fifo_push & s_tlast_i);
        end

        if (start_ok) begin
            err_d = 1'b0;
        end else if (axi_bvalid_i && (axi_bresp_i != RESP_OKAY)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (burst_end) begin
            beat_d    = {BEAT_W{1'b0}};
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            aw_done_d = aw_done_q | aw_hs;
            if (w_hs) begin
                if (last_beat) begin
                    w_done_d = 1'b1;
                    beat_d   = beat_q;
                end else begin
                    w_done_d = w_done_q;
                    beat_d   = beat_q + BEAT_W'(1);
                end
            end else begin
                w_done_d = w_done_q;
                beat_d   = beat_q;
            end
        end

        case ({outst_inc, outst_dec})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        done_d = (state_q == BW_FLUSH) && (outst_d == {OUT_W{1'b0}});
    end

    // Datapath and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= {ADDRS{1'b0}};
            beat_q      <= {BEAT_W{1'b0}};
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            outst_q     <= {OUT_W{1'b0}};
        end else begin
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
            done_q      <= done_d;
            outst_q     <= outst_d;
        end
    end

    assign done_o        = done_q;
    assign err_o         = err_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = REQID'(AXI_ID);
    assign axi_awlen_o   = 8'(BURST_LEN - 1);
    assign axi_awburst_o = BURST_INCR;
    assign axi_bready_o  = 1'b1;

endmodule

// File: tb/tb_axis_ddr3_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_axis_ddr3_burst_writer
// Random-data bench: a reference model derives, from the word list and base
// address of each transfer, the expected AW addresses and W beats (data,
// strobes, wlast, zero padding) and compares them with what the AXI slave
// model observed.
// ---------------------------------------------------------------------------
module tb_axis_ddr3_burst_writer;

    localparam int WIDTH = 32;
    localparam int ADDRS = 27;
    localparam int REQID = 4;
    localparam int BL    = 4;
    localparam int MAXO  = 2;

    logic               clock;
    logic               reset;
    logic               start_i;
    logic [ADDRS-1:0]   base_i;
    logic               busy_o, done_o, err_o;
    logic               s_tvalid_i, s_tready_o, s_tlast_i;
    logic [WIDTH-1:0]   s_tdata_i;
    logic               axi_awvalid_o, axi_awready_i;
    logic [ADDRS-1:0]   axi_awaddr_o;
    logic [REQID-1:0]   axi_awid_o;
    logic [7:0]         axi_awlen_o;
    logic [1:0]         axi_awburst_o;
    logic               axi_wvalid_o, axi_wready_i, axi_wlast_o;
    logic [3:0]         axi_wstrb_o;
    logic [WIDTH-1:0]   axi_wdata_o;
    logic               axi_bvalid_i, axi_bready_o;
    logic [1:0]         axi_bresp_i;
    logic [REQID-1:0]   axi_bid_i;

    axis_ddr3_burst_writer #(
        .WIDTH(WIDTH), .ADDRS(ADDRS), .REQID(REQID),
        .BURST_LEN(BL), .MAX_OUTST(MAXO), .AXI_ID(0)
    ) dut (
        .clock(clock), .reset(reset), .start_i(start_i), .base_i(base_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i), .axi_awaddr_o(axi_awaddr_o),
        .axi_awid_o(axi_awid_o), .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i), .axi_wlast_o(axi_wlast_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wdata_o(axi_wdata_o),
        .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
        .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour knobs, written only by the main sequence.
    int aw_delay_cfg = 0;
    bit wtoggle_cfg  = 1'b0;
    bit b_hold_cfg   = 1'b0;
    int err_at       = -1;

    // Observations, written only by the monitor.
    logic [40:0] aw_q[$];
    logic [36:0] w_q[$];
    int aw_cnt = 0, wlast_cnt = 0, done_cnt = 0, gap_cnt = 0;
    bit w_pending = 1'b0;

    // Slave state.
    int aw_wait = 0;
    int b_issued = 0;

    // Main-sequence bookkeeping.
    logic [WIDTH-1:0] exp_words[$];
    int aw_base, w_base, done_base, gap_base;
    int stream_stuck;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AXI slave model: delayed AWREADY, optionally toggling WREADY, one B per completed burst.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            aw_wait       = 0;
            b_issued      = 0;
            axi_awready_i = 1'b0;
            axi_wready_i  = 1'b0;
            axi_bvalid_i  = 1'b0;
            axi_bresp_i   = 2'b00;
        end else begin
            if (axi_awvalid_o) aw_wait++;
            else aw_wait = 0;
            axi_awready_i = (aw_wait > aw_delay_cfg);
            if (wtoggle_cfg) axi_wready_i = ~axi_wready_i;
            else axi_wready_i = 1'b1;
            if (!b_hold_cfg && b_issued < ((aw_cnt < wlast_cnt) ? aw_cnt : wlast_cnt)) begin
                axi_bvalid_i = 1'b1;
                axi_bresp_i  = (b_issued == err_at) ? 2'b10 : 2'b00;
                b_issued++;
            end else begin
                axi_bvalid_i = 1'b0;
                axi_bresp_i  = 2'b00;
            end
        end
    end

    // Bus monitor: records handshakes that complete at the next rising edge.
    always @(negedge clock) begin
        if (reset) begin
            aw_cnt    = 0;
            wlast_cnt = 0;
            w_pending = 1'b0;
        end else begin
            if (axi_awvalid_o && axi_awready_i) begin
                aw_q.push_back({axi_awburst_o, axi_awlen_o, axi_awid_o, axi_awaddr_o});
                aw_cnt++;
            end
            if (w_pending && !axi_wvalid_o) gap_cnt++;
            if (axi_wvalid_o && axi_wready_i) begin
                w_q.push_back({axi_wlast_o, axi_wstrb_o, axi_wdata_o});
                if (axi_wlast_o) wlast_cnt++;
            end
            w_pending = axi_wvalid_o && !(axi_wready_i && axi_wlast_o);
            if (done_o) done_cnt++;
        end
    end

    task automatic start_xfer(input logic [ADDRS-1:0] base);
        exp_words.delete();
        aw_base      = aw_q.size();
        w_base       = w_q.size();
        done_base    = done_cnt;
        gap_base     = gap_cnt;
        stream_stuck = 0;
        base_i  = base;
        start_i = 1'b1;
        @(posedge clock); #1;
        start_i = 1'b0;
    endtask

    task automatic send_words(input int n, input bit with_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int  t;
            bit  ok;
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid_i = 1'b0;
                @(posedge clock); #1;
            end
            s_tvalid_i = 1'b1;
            s_tdata_i  = $urandom;
            s_tlast_i  = with_last && (i == n - 1);
            exp_words.push_back(s_tdata_i);
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 2000) begin
                @(negedge clock);
                ok = s_tready_o;
                @(posedge clock); #1;
                t++;
            end
            if (!ok) stream_stuck++;
        end
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (busy_o && t < 3000);
        check_eq("idle_timeout", {63'd0, busy_o}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    // Reference model: bursts of BL beats from base, padding after the last word.
    task automatic check_xfer(input logic [ADDRS-1:0] base);
        int n, nb;
        n  = exp_words.size();
        nb = (n + BL - 1) / BL;
        check_eq("stream_stuck", stream_stuck, 0);
        check_eq("aw_count", aw_q.size() - aw_base, nb);
        for (int k = 0; k < nb; k++) begin
            longint a;
            logic [40:0] ea;
            a  = (longint'(base) + longint'(k * BL * (WIDTH / 8))) % (longint'(1) << ADDRS);
            ea = {2'b01, 8'(BL - 1), 4'd0, a[ADDRS-1:0]};
            if (aw_base + k < aw_q.size()) check_eq("aw_entry", aw_q[aw_base + k], ea);
        end
        check_eq("w_count", w_q.size() - w_base, nb * BL);
        for (int i = 0; i < nb * BL; i++) begin
            logic [36:0] ew;
            if (i < n) ew = {(i % BL) == (BL - 1), 4'hF, exp_words[i]};
            else       ew = {(i % BL) == (BL - 1), 4'h0, 32'h0};
            if (w_base + i < w_q.size()) check_eq("w_beat", w_q[w_base + i], ew);
        end
        check_eq("done_pulses", done_cnt - done_base, 1);
        check_eq("wvalid_gap", gap_cnt - gap_base, 0);
        check_eq("busy_after", {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; base_i = '0;
        s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tdata_i = '0;
        axi_bid_i = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset values
        @(negedge clock);
        check_eq("rst_busy",    {63'd0, busy_o}, 64'd0);
        check_eq("rst_done",    {63'd0, done_o}, 64'd0);
        check_eq("rst_err",     {63'd0, err_o}, 64'd0);
        check_eq("rst_tready",  {63'd0, s_tready_o}, 64'd0);
        check_eq("rst_awvalid", {63'd0, axi_awvalid_o}, 64'd0);
        check_eq("rst_wvalid",  {63'd0, axi_wvalid_o}, 64'd0);
        check_eq("rst_bready",  {63'd0, axi_bready_o}, 64'd1);
        check_eq("rst_awconst", {axi_awburst_o, axi_awlen_o, axi_awid_o}, {2'b01, 8'd3, 4'd0});
        check_eq("rst_awaddr",  axi_awaddr_o, 0);
        check_eq("rst_wpay",    {axi_wlast_o, axi_wstrb_o, axi_wdata_o}, 0);
        @(posedge clock); #1;

        // 8 words, no backpressure
        start_xfer(27'h100); send_words(8, 1'b1, 1'b0); wait_idle(); check_xfer(27'h100);
        check_eq("t1_err", {63'd0, err_o}, 64'd0);

        // 5 words: second burst padded
        start_xfer(27'h0); send_words(5, 1'b1, 1'b0); wait_idle(); check_xfer(27'h0);

        // Backpressure on both channels, gappy stream
        aw_delay_cfg = 5; wtoggle_cfg = 1'b1;
        start_xfer(27'h400); send_words(12, 1'b1, 1'b1); wait_idle(); check_xfer(27'h400);
        aw_delay_cfg = 0; wtoggle_cfg = 1'b0;

        // First B is SLVERR
        err_at = b_issued;
        start_xfer(27'h200); send_words(8, 1'b1, 1'b0); wait_idle(); check_xfer(27'h200);
        check_eq("err_sticky", {63'd0, err_o}, 64'd1);
        err_at = -1;
        start_xfer(27'h300);
        check_eq("err_cleared", {63'd0, err_o}, 64'd0);
        send_words(3, 1'b1, 1'b1); wait_idle(); check_xfer(27'h300);

        // Outstanding limit with B withheld
        b_hold_cfg = 1'b1;
        start_xfer(27'h100); send_words(16, 1'b1, 1'b0);
        repeat (40) @(posedge clock);
        #1;
        check_eq("outst_aw_count", aw_q.size() - aw_base, 2);
        check_eq("outst_busy", {63'd0, busy_o}, 64'd1);
        b_hold_cfg = 1'b0;
        wait_idle(); check_xfer(27'h100);

        // Address wrap, plus AWVALID latency after the 4th word
        start_xfer(27'h7FFFFF0); send_words(4, 1'b0, 1'b0);
        check_eq("aw_latency", {63'd0, axi_awvalid_o}, 64'd1);
        send_words(4, 1'b1, 1'b0); wait_idle(); check_xfer(27'h7FFFFF0);

        // Reset in the middle of a burst
        begin
            int t;
            start_xfer(27'h80); send_words(4, 1'b0, 1'b0);
            t = 0;
            do begin
                @(negedge clock); #1;
                t++;
            end while ((w_q.size() - w_base) < 2 && t < 200);
            check_eq("mid_beats", (w_q.size() - w_base) >= 2, 1);
            @(posedge clock); #1;
            reset = 1'b1;
            @(posedge clock); #1;
            check_eq("mr_awvalid", {63'd0, axi_awvalid_o}, 64'd0);
            check_eq("mr_wvalid",  {63'd0, axi_wvalid_o}, 64'd0);
            check_eq("mr_busy",    {63'd0, busy_o}, 64'd0);
            check_eq("mr_tready",  {63'd0, s_tready_o}, 64'd0);
            @(posedge clock); #1;
            reset = 1'b0;
            @(posedge clock); #1;
        end
        start_xfer(27'h40); send_words(6, 1'b1, 1'b1); wait_idle(); check_xfer(27'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
